sm_dbg_probe: RTL and testbench
===============================

# sm_dbg_probe

Host-side reader for the CPU's 8-bit debug port: it drives the CPU's `dbgIn` select byte and samples `dbgOut` to reassemble full 32-bit values, one byte slice at a time. It reads either a register-file entry (register 0 returns PC) or the live ALU result, and returns the assembled word over a valid/ready response channel. It sits beside `sm_cpu` in the top level and feeds board-level display and host logic.

## Interface
- `SETTLE`, 1: extra cycles each byte select is held before its byte is sampled (1..15).
- `IDLE_SEL`, 8'h80: select byte driven while idle (register mode, addr 0, byte 0, i.e. PC[7:0]).
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: clock, shared with `sm_cpu`.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: read request.
- `req_ready` out 1: request accepted when both are high at `clk` edge.
- `req_mode` in 1: 1 = register/PC, 0 = ALU result.
- `req_addr` in 5: register index; in ALU mode it is don't-care but still driven into `dbgSel[4:0]`.
- `rsp_valid` out 1: assembled word available.
- `rsp_ready` in 1: consumer accepts the word.
- `rsp_data` out 32: assembled word.
- `rsp_addr` out 5: echo of the index that was read.
- `rsp_mode` out 1: echo of the mode that was read.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `scan_start` in 1: starts a full register scan; present only with `SM_DBG_PROBE_SCAN_EN`.
- `dbgSel` out 8: connects to CPU `dbgIn`; bit [7] = mode, bits [6:5] = byte index, bits [4:0] = addr.
- `dbgData` in 8: connects to CPU `dbgOut`; carries the selected value shifted right by 8×byte.

## Operation
- FSM states: IDLE, HOLD, CAP, DONE.
- IDLE:
  - `req_ready` = 1, `dbgSel` = `IDLE_SEL`.
  - On accept, latch mode and addr, drive byte index 0, go to HOLD.
- HOLD: hold `dbgSel` for `SETTLE` cycles, tracked by a settle counter.
- CAP (one cycle):
  - Sample `dbgData` into `rsp_data[8k+7:8k]`, where k is the current byte index.
  - If k < 3: increment k, update `dbgSel[6:5]`, return to HOLD.
  - Else: go to DONE.
- DONE:
  - `rsp_valid` = 1; `rsp_data`, `rsp_addr` and `rsp_mode` stay stable.
  - On `rsp_valid & rsp_ready`, return to IDLE. Without scan enabled, the next request is accepted one cycle later at the earliest.
- `req_ready` is 0 in every state except IDLE.
- Bytes are captured non-atomically. If the CPU advances between captures, the word may tear; halting the CPU is the integrator's responsibility.
- Reset values: FSM in IDLE, `dbgSel` = `IDLE_SEL`, `rsp_valid` = 0, `rsp_data` = 0, `rsp_addr` = 0, `rsp_mode` = 0, `busy` = 0, `req_ready` = 1.
- Reset mid-operation discards partial data and returns to IDLE on the same edge.

## Timing
- `dbgSel` updates on the accept edge.
- Each byte occupies `SETTLE` + 1 cycles (HOLD plus CAP).
- `rsp_valid` rises 4×(`SETTLE`+1) cycles after the accept edge; that is 8 cycles for `SETTLE` = 1.
- A byte is sampled at the edge that ends its CAP cycle.
- `dbgData` must be combinationally valid within one cycle of a `dbgSel` change.

## Configuration
- `SM_DBG_PROBE_SCAN_EN` defined:
  - `scan_start` exists. When it is high in IDLE and `req_valid` is low, the probe reads registers 0..31 in order, mode 1.
  - Each register produces one DONE/handshake with `rsp_addr` = index; after the handshake the probe proceeds straight to the next index.
  - `req_ready` = 0 for the whole scan.
  - If `req_valid` and `scan_start` are both high, the request wins; `scan_start` is not latched and must still be high when IDLE is re-entered.
- `SM_DBG_PROBE_SCAN_EN` undefined: no `scan_start` port and no scan logic.

## Test plan
- Register read: `SETTLE` = 1, CPU halted, reg 5 = 0xDEADBEEF, request mode 1 addr 5.
  - `dbgSel` sequence is 0x85, 0xA5, 0xC5, 0xE5.
  - `rsp_valid` rises exactly 8 cycles after accept.
  - `rsp_data` = 0xDEADBEEF, `rsp_addr` = 5, `rsp_mode` = 1.
- PC read: request mode 1 addr 0 with PC = 0x00000123 → `rsp_data` = 0x00000123.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles.
  - `rsp_valid`, `rsp_data`, `rsp_addr` and `rsp_mode` stay stable.
  - `req_ready` stays 0, and a pending request is accepted the cycle after the handshake.
- ALU mode: request mode 0 addr 0 with a stub driving `dbgData` = byte index + 0x10.
  - `dbgSel` sequence is 0x00, 0x20, 0x40, 0x60.
  - `rsp_data` = 0x13121110.
- Reset mid-operation: assert `rst` one cycle after the byte-2 capture.
  - Next cycle: `rsp_valid` = 0, `busy` = 0, `dbgSel` = 0x80.
  - A following request returns the correct value.
- Scan (macro defined): reg i = 0x01010101×i, PC = 0x40, `rsp_ready` = 1.
  - 32 responses with `rsp_addr` 0..31; addr 0 returns 0x40.
  - `req_valid` raised together with `scan_start` is served first.

Source files
------------

// File: rtl/sm_dbg_probe.sv
// Debug-port reader: walks dbgSel through four byte slices and reassembles a 32-bit word.
// Optional full register scan enabled by defining SM_DBG_PROBE_SCAN_EN.
module sm_dbg_probe #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [7:0]  IDLE_SEL = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [4:0]  req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_addr,
  output logic        rsp_mode,
  output logic        busy,
`ifdef SM_DBG_PROBE_SCAN_EN
  input  logic        scan_start,
`endif
  output logic [7:0]  dbgSel,
  input  logic [7:0]  dbgData
);

  typedef enum logic [1:0] {IDLE, HOLD, CAP, DONE} state_t;

  state_t      state, stateNxt;
  logic [1:0]  byteIdx;
  logic [3:0]  settleCnt;
  logic        modeQ;
  logic [4:0]  addrQ;
  logic [31:0] dataQ;
  logic        reqAccept;
  logic        scanGo;
  logic        scanNext;
`ifdef SM_DBG_PROBE_SCAN_EN
  logic        scanQ;
`endif

  always_comb begin
    stateNxt  = state;
    reqAccept = 1'b0;
    scanGo    = 1'b0;
    scanNext  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          reqAccept = 1'b1;
          stateNxt  = HOLD;
        end
`ifdef SM_DBG_PROBE_SCAN_EN
        else if (scan_start) begin
          scanGo   = 1'b1;
          stateNxt = HOLD;
        end
`endif
      end
      HOLD: if (settleCnt == 4'(SETTLE - 1)) stateNxt = CAP;
      CAP:  stateNxt = (byteIdx == 2'd3) ? DONE : HOLD;
      DONE: begin
        if (rsp_ready) begin
          stateNxt = IDLE;
`ifdef SM_DBG_PROBE_SCAN_EN
          // A scan chains straight into the next register after each handshake.
          if (scanQ && (addrQ != 5'd31)) begin
            scanNext = 1'b1;
            stateNxt = HOLD;
          end
`endif
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byteIdx   <= 2'd0;
      settleCnt <= 4'd0;
      modeQ     <= 1'b0;
      addrQ     <= 5'd0;
      dataQ     <= 32'd0;
`ifdef SM_DBG_PROBE_SCAN_EN
      scanQ     <= 1'b0;
`endif
    end else begin
      state <= stateNxt;
      case (state)
        IDLE: begin
          if (reqAccept) begin
            modeQ <= req_mode;
            addrQ <= req_addr;
          end else if (scanGo) begin
            modeQ <= 1'b1;
            addrQ <= 5'd0;
          end
          byteIdx   <= 2'd0;
          settleCnt <= 4'd0;
`ifdef SM_DBG_PROBE_SCAN_EN
          scanQ     <= scanGo;
`endif
        end
        HOLD: settleCnt <= settleCnt + 4'd1;
        CAP: begin
          // Byte k lands in bits [8k+7:8k]; byteIdx wraps to 0 after the last slice.
          dataQ[{byteIdx, 3'b000} +: 8] <= dbgData;
          byteIdx   <= byteIdx + 2'd1;
          settleCnt <= 4'd0;
        end
        DONE: begin
          if (scanNext) begin
            addrQ     <= addrQ + 5'd1;
            byteIdx   <= 2'd0;
            settleCnt <= 4'd0;
          end
`ifdef SM_DBG_PROBE_SCAN_EN
          if (rsp_ready && !scanNext) scanQ <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_data  = dataQ;
  assign rsp_addr  = addrQ;
  assign rsp_mode  = modeQ;
  assign dbgSel    = (state == IDLE) ? IDLE_SEL : {modeQ, byteIdx, addrQ};

endmodule

// File: tb/tb_sm_dbg_probe.sv
// Bench for sm_dbg_probe: CPU debug-port stub, table vectors, random reads and corner sequences.
module tb_sm_dbg_probe;
  localparam int SETTLE   = 1;
  localparam int BYTE_CYC = SETTLE + 1;
  localparam int LAT      = 4 * BYTE_CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_mode = 1'b0;
  logic [4:0]  req_addr = 5'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_addr;
  logic        rsp_mode;
  logic        busy;
  logic        scan_start = 1'b0;
  logic [7:0]  dbgSel;
  logic [7:0]  dbgData;

  logic [31:0] regs [32];
  logic [31:0] alu;
  logic [31:0] stubWord;

  int errors = 0;
  int checks = 0;

  sm_dbg_probe #(.SETTLE(SETTLE), .IDLE_SEL(8'h80)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_mode(rsp_mode), .busy(busy),
`ifdef SM_DBG_PROBE_SCAN_EN
    .scan_start(scan_start),
`endif
    .dbgSel(dbgSel), .dbgData(dbgData)
  );

  always #5 clk = ~clk;

  // CPU stub: selected value shifted right by 8 x byte index.
  always_comb begin
    stubWord = dbgSel[7] ? regs[dbgSel[4:0]] : alu;
    dbgData  = 8'(stubWord >> (8 * int'(dbgSel[6:5])));
  end

  typedef struct {
    logic        m;
    logic [4:0]  a;
    logic [31:0] val;
    logic [31:0] exp;
    int          bp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic m, input logic [4:0] a);
    return m ? regs[a] : alu;
  endfunction

  task automatic issueReq(input logic m, input logic [4:0] a, input logic sc, input string nm);
    @(negedge clk);
    req_mode   = m;
    req_addr   = a;
    req_valid  = 1'b1;
    scan_start = sc;
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Follows one transaction from the accept edge to DONE, checking select slices and latency.
  task automatic collect(input logic m, input logic [4:0] a, input logic [31:0] exp, input string nm);
    int j;
    logic [7:0] expSel;
    for (j = 0; j <= LAT + 20; j++) begin
      @(negedge clk);
      if (rsp_valid) break;
      expSel = {m, 2'(j / BYTE_CYC), a};
      chk($sformatf("%s sel[%0d]", nm, j), 32'(dbgSel), 32'(expSel));
    end
    chk({nm, " latency"}, 32'(j), 32'(LAT));
    chk({nm, " data"}, rsp_data, exp);
    chk({nm, " addr"}, 32'(rsp_addr), 32'(a));
    chk({nm, " mode"}, 32'(rsp_mode), 32'(m));
  endtask

  task automatic finishRsp(input int bp, input string nm);
    logic [31:0] d;
    logic [4:0]  a;
    logic        m;
    d = rsp_data; a = rsp_addr; m = rsp_mode;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({nm, " bp valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, " bp data"}, rsp_data, d);
      chk({nm, " bp addr"}, 32'(rsp_addr), 32'(a));
      chk({nm, " bp mode"}, 32'(rsp_mode), 32'(m));
      chk({nm, " bp req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, " post valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, " post busy"}, 32'(busy), 32'd0);
  endtask

  task automatic doRead(input logic m, input logic [4:0] a, input logic [31:0] exp, input int bp,
                        input string nm);
    issueReq(m, a, 1'b0, nm);
    collect(m, a, exp, nm);
    finishRsp(bp, nm);
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        m;
    logic [4:0]  a;
    logic [31:0] v;
    int          got;

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    alu = $urandom;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 0};
    vecs[1] = '{1'b1, 5'd0,  32'h00000123, 32'h00000123, 0};
    vecs[2] = '{1'b0, 5'd0,  32'h13121110, 32'h13121110, 0};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 5};
    vecs[4] = '{1'b0, 5'd17, 32'hA5A55A5A, 32'hA5A55A5A, 2};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset dbgSel", 32'(dbgSel), 32'h80);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_data", rsp_data, 32'd0);
    chk("reset rsp_addr", 32'(rsp_addr), 32'd0);
    chk("reset rsp_mode", 32'(rsp_mode), 32'd0);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].m) regs[vecs[i].a] = vecs[i].val;
      else           alu = vecs[i].val;
      doRead(vecs[i].m, vecs[i].a, vecs[i].exp, vecs[i].bp, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      m = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 31));
      v = $urandom;
      if (m) regs[a] = v;
      else   alu = v;
      doRead(m, a, modelRead(m, a), $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    // Pending request held during backpressure is accepted right after the handshake.
    regs[5] = 32'hCAFEF00D;
    regs[3] = 32'h0BADBEEF;
    issueReq(1'b1, 5'd5, 1'b0, "pend");
    collect(1'b1, 5'd5, 32'hCAFEF00D, "pend");
    req_mode = 1'b1; req_addr = 5'd3; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pend hold req_ready", 32'(req_ready), 32'd0);
      chk("pend hold valid", 32'(rsp_valid), 32'd1);
      chk("pend hold data", rsp_data, 32'hCAFEF00D);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("pend ready after hs", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    collect(1'b1, 5'd3, 32'h0BADBEEF, "pend2");
    finishRsp(0, "pend2");

    // Reset one cycle after the byte-2 capture.
    regs[7] = 32'h89ABCDEF;
    issueReq(1'b1, 5'd7, 1'b0, "rstmid");
    repeat (3 * BYTE_CYC) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid dbgSel", 32'(dbgSel), 32'h80);
    chk("rstmid rsp_data", rsp_data, 32'd0);
    doRead(1'b1, 5'd7, modelRead(1'b1, 5'd7), 0, "rstmid after");

`ifdef SM_DBG_PROBE_SCAN_EN
    for (int i = 1; i < 32; i++) regs[i] = 32'h01010101 * i;
    regs[0] = 32'h40;
    alu = 32'h5EED1234;
    issueReq(1'b0, 5'd9, 1'b1, "scanreq");
    collect(1'b0, 5'd9, 32'h5EED1234, "scanreq");
    rsp_ready = 1'b1;
    @(posedge clk);
    got = 0;
    for (int c = 0; c < 1500 && got < 32; c++) begin
      @(negedge clk);
      if (busy) scan_start = 1'b0;
      if (busy) chk("scan req_ready", 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        chk($sformatf("scan addr%0d", got), 32'(rsp_addr), 32'(got));
        chk($sformatf("scan data%0d", got), rsp_data, (got == 0) ? 32'h40 : 32'h01010101 * got);
        chk($sformatf("scan mode%0d", got), 32'(rsp_mode), 32'd1);
        got++;
      end
    end
    chk("scan count", 32'(got), 32'd32);
    repeat (3) @(negedge clk);
    chk("scan end busy", 32'(busy), 32'd0);
    rsp_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
